// File: rtl/reg_dump_if.sv
// Output stream of the register dump reader.
//
// Handshake: a beat moves when out_valid && out_ready are both high on a
// rising clock edge. While out_valid is high and out_ready is low, the
// master holds out_data/out_idx/out_last/out_csum unchanged. The master may
// withdraw out_valid without a handshake only when it abandons the dump.
//
// Signals:
//   out_valid  master->slave  beat valid
//   out_ready  slave->master  slave accepts beat
//   out_data   master->slave  register value or checksum word
//   out_idx    master->slave  register index of out_data (0 on checksum beat)
//   out_last   master->slave  final beat of the dump
//   out_csum   master->slave  beat carries the checksum word
interface reg_dump_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_idx;
  logic              out_last;
  logic              out_csum;

  modport master (
    output out_valid, out_data, out_idx, out_last, out_csum,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_idx, out_last, out_csum,
    output out_ready
  );
endinterface

// File: rtl/reg_dump_reader.sv
// Debug reader for the register bank.
//
// On a start pulse it requests a core halt, waits for the acknowledge (with
// a timeout), then reads a contiguous, modulo-32 wrapping range of register
// indices through the debug read port and streams each value with its index.
// The core is released when the dump finishes or is abandoned.
//
// Optional feature (macro DUMP_CHECKSUM_EN): a running XOR of all dumped
// words is appended as one extra beat (out_idx=0, out_csum=1, out_last=1).
//
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   start            one-cycle dump request, only sampled in IDLE
//   first_idx        first register index, sampled with start
//   last_idx         last register index, sampled with start
//   cpu_halt_req     request to the core to stop writing the register bank
//   cpu_halted       core halt acknowledge, must stay high during the dump
//   rf_addr          debug read address (follows the index during READ)
//   rf_data          combinational read data for rf_addr
//   dump             output stream (reg_dump_if master)
//   busy             high in every state except IDLE
//   done             one-cycle pulse on normal completion
//   aborted          one-cycle pulse on halt timeout or halt loss
//   state_dbg        current FSM state encoding
module reg_dump_reader #(
  parameter int DATA_W       = 64,
  parameter int ADDR_W       = 5,
  parameter int HALT_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_idx,
  input  logic [ADDR_W-1:0] last_idx,
  output logic              cpu_halt_req,
  input  logic              cpu_halted,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  reg_dump_if.master        dump,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [2:0]        state_dbg
);

  localparam int CNT_W = $clog2(HALT_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_HALT_WAIT = 3'd1,
    S_READ      = 3'd2,
    S_SEND      = 3'd3,
    S_FINISH    = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] last_q;
  logic [ADDR_W-1:0] rf_addr_q;
  logic [DATA_W-1:0] out_data_q;
  logic [ADDR_W-1:0] out_idx_q;
  logic              out_last_q;
  logic [CNT_W-1:0]  halt_cnt_q;

  // strobes from the FSM to the datapath
  logic start_en;
  logic cap_en;
  logic adv_en;
  logic cnt_en;

`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;
  logic              reg_last_q;   // current register beat is the last register
  logic              out_csum_q;
  logic              csum_beat_en;
`endif

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    start_en = 1'b0;
    cap_en   = 1'b0;
    adv_en   = 1'b0;
    cnt_en   = 1'b0;
    done     = 1'b0;
    aborted  = 1'b0;
`ifdef DUMP_CHECKSUM_EN
    csum_beat_en = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          start_en = 1'b1;
          state_d  = S_HALT_WAIT;
        end
      end
      S_HALT_WAIT: begin
        if (cpu_halted) begin
          state_d = S_READ;
        end else if (halt_cnt_q == CNT_W'(HALT_TIMEOUT - 1)) begin
          // this is the HALT_TIMEOUT-th wait cycle without an acknowledge
          aborted = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      S_READ: begin
        if (!cpu_halted) begin
          aborted = 1'b1;
          state_d = S_IDLE;
        end else begin
          cap_en  = 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (!cpu_halted) begin
          // pending beat is discarded
          aborted = 1'b1;
          state_d = S_IDLE;
        end else if (dump.out_ready) begin
          if (out_last_q) begin
            state_d = S_FINISH;
`ifdef DUMP_CHECKSUM_EN
          end else if (reg_last_q) begin
            // last register accepted: stay in SEND with the checksum beat
            csum_beat_en = 1'b1;
`endif
          end else begin
            adv_en  = 1'b1;
            state_d = S_READ;
          end
        end
      end
      S_FINISH: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q      <= '0;
      last_q     <= '0;
      rf_addr_q  <= '0;
      out_data_q <= '0;
      out_idx_q  <= '0;
      out_last_q <= 1'b0;
      halt_cnt_q <= '0;
`ifdef DUMP_CHECKSUM_EN
      csum_q     <= '0;
      reg_last_q <= 1'b0;
      out_csum_q <= 1'b0;
`endif
    end else begin
      halt_cnt_q <= cnt_en ? halt_cnt_q + 1'b1 : '0;

      if (start_en) begin
        idx_q  <= first_idx;
        last_q <= last_idx;
`ifdef DUMP_CHECKSUM_EN
        csum_q <= '0;
`endif
      end

      if (cap_en) begin
        rf_addr_q  <= idx_q;
        out_data_q <= rf_data;
        out_idx_q  <= idx_q;
`ifdef DUMP_CHECKSUM_EN
        out_last_q <= 1'b0;
        out_csum_q <= 1'b0;
        reg_last_q <= (idx_q == last_q);
        csum_q     <= csum_q ^ rf_data;
`else
        out_last_q <= (idx_q == last_q);
`endif
      end

      // index width equals the bank size, so the increment wraps mod 32
      if (adv_en) idx_q <= idx_q + 1'b1;

`ifdef DUMP_CHECKSUM_EN
      if (csum_beat_en) begin
        out_data_q <= csum_q;
        out_idx_q  <= '0;
        out_last_q <= 1'b1;
        out_csum_q <= 1'b1;
        reg_last_q <= 1'b0;
      end
`endif
    end
  end

  // rf_data is combinational, so the address must be live during READ itself
  assign rf_addr = (state_q == S_READ) ? idx_q : rf_addr_q;

  assign busy         = (state_q != S_IDLE);
  assign cpu_halt_req = busy;
  // gated by cpu_halted so a beat is never accepted in the halt-loss cycle
  assign dump.out_valid = (state_q == S_SEND) && cpu_halted;
  assign dump.out_data  = out_data_q;
  assign dump.out_idx   = out_idx_q;
  assign dump.out_last  = out_last_q;
`ifdef DUMP_CHECKSUM_EN
  assign dump.out_csum  = out_csum_q;
`else
  assign dump.out_csum  = 1'b0;
`endif
  assign state_dbg = state_q;

endmodule
